// File: rtl/cw_trig_capture.sv
// Trigger-and-capture engine: probe sampling, per-bus trigger evaluation and ring-buffer writes.
// Optional macro CW_TRIG_CNT_EN: trigger only after trig_cnt combined hits in WAIT.
module cw_trig_capture #(
  parameter int BUS_NUM    = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                           trig_clk,
  input  logic                           trig_rst,
  input  logic [BUS_NUM*BUS_WIDTH-1:0]   bus_din,
  input  logic                           arm,
  input  logic                           abort,
  input  logic [2*BUS_NUM-1:0]           trig_mode,
  input  logic [BUS_NUM*BUS_WIDTH-1:0]   trig_value,
  input  logic [BUS_NUM*BUS_WIDTH-1:0]   trig_mask,
  input  logic                           trig_and,
  input  logic [ADDR_WIDTH-1:0]          pre_len,
  input  logic [CNT_WIDTH-1:0]           trig_cnt,
  output logic                           wt_ce,
  output logic                           wt_en,
  output logic [ADDR_WIDTH-1:0]          wt_addr,
  output logic [BUS_NUM*BUS_WIDTH-1:0]   wt_data,
  output logic                           armed,
  output logic                           triggered,
  output logic                           done,
  output logic [ADDR_WIDTH-1:0]          trig_addr
);

  localparam int DW = BUS_NUM * BUS_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         sample_q, prev_q;
  logic [ADDR_WIDTH-1:0] addr_q, cnt_q, cnt_inc, pre_eff_q, post_len, trig_addr_q;
  logic                  trig_q;
  logic [BUS_NUM-1:0]    bus_en, bus_hit;
  logic                  comb_hit, qual_hit, writing, start;

  // Per-bus hit evaluation on the registered sample
  for (genvar b = 0; b < BUS_NUM; b++) begin : g_bus
    logic [1:0]           mode;
    logic [BUS_WIDTH-1:0] s_m, v_m, chg;
    assign mode = trig_mode[2*b +: 2];
    assign s_m  = sample_q[b*BUS_WIDTH +: BUS_WIDTH] & trig_mask[b*BUS_WIDTH +: BUS_WIDTH];
    assign v_m  = trig_value[b*BUS_WIDTH +: BUS_WIDTH] & trig_mask[b*BUS_WIDTH +: BUS_WIDTH];
    assign chg  = (sample_q[b*BUS_WIDTH +: BUS_WIDTH] ^ prev_q[b*BUS_WIDTH +: BUS_WIDTH])
                & trig_mask[b*BUS_WIDTH +: BUS_WIDTH];
    assign bus_en[b]  = |mode;
    assign bus_hit[b] = ((mode == 2'b01) && (s_m == v_m)) ||
                        ((mode == 2'b10) && (s_m != v_m)) ||
                        ((mode == 2'b11) && (|chg));
  end

  // With every bus off the condition is trivially true
  assign comb_hit = (~|bus_en) ? 1'b1
                  : (trig_and ? (&(bus_hit | ~bus_en)) : (|(bus_hit & bus_en)));

  assign writing  = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign start    = arm && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign cnt_inc  = cnt_q + 1'b1;
  assign post_len = ~pre_eff_q;

`ifdef CW_TRIG_CNT_EN
  logic [CNT_WIDTH-1:0] hcnt_q;
  logic [CNT_WIDTH:0]   hcnt_next;
  assign hcnt_next = {1'b0, hcnt_q} + 1'b1;
  // trig_cnt of 0 or 1 both mean "first hit"
  assign qual_hit  = comb_hit && (hcnt_next >= {1'b0, trig_cnt});

  always_ff @(posedge trig_clk or posedge trig_rst) begin
    if (trig_rst) begin
      hcnt_q <= '0;
    end else if (start) begin
      hcnt_q <= '0;
    end else if ((state_q == S_WAIT) && comb_hit && !abort) begin
      hcnt_q <= hcnt_next[CNT_WIDTH-1:0];
    end
  end
`else
  logic unused_trig_cnt;
  assign unused_trig_cnt = ^trig_cnt;
  assign qual_hit        = comb_hit;
`endif

  always_ff @(posedge trig_clk or posedge trig_rst) begin
    if (trig_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: if (arm) state_d = (pre_len == '0) ? S_WAIT : S_PRE;
        S_PRE:          if (cnt_inc == pre_eff_q) state_d = S_WAIT;
        S_WAIT:         if (qual_hit) state_d = (post_len == '0) ? S_DONE : S_POST;
        S_POST:         if (cnt_inc == post_len) state_d = S_DONE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Stage p0: probe sample and its predecessor for edge detection
  always_ff @(posedge trig_clk or posedge trig_rst) begin
    if (trig_rst) begin
      sample_q <= '0;
      prev_q   <= '0;
    end else begin
      sample_q <= bus_din;
      prev_q   <= sample_q;
    end
  end

  // Stage p1: write address, phase counter and trigger bookkeeping
  always_ff @(posedge trig_clk or posedge trig_rst) begin
    if (trig_rst) begin
      addr_q      <= '0;
      cnt_q       <= '0;
      pre_eff_q   <= '0;
      trig_addr_q <= '0;
      trig_q      <= 1'b0;
    end else if (start) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      pre_eff_q <= pre_len;
      trig_q    <= 1'b0;
    end else if (writing) begin
      addr_q <= addr_q + 1'b1;
      cnt_q  <= (state_d == state_q) ? cnt_inc : '0;
      if ((state_q == S_WAIT) && qual_hit && !abort) begin
        trig_addr_q <= addr_q;
        trig_q      <= 1'b1;
      end
    end
  end

  assign wt_ce     = writing;
  assign wt_en     = writing;
  assign wt_addr   = addr_q;
  assign wt_data   = sample_q;
  assign armed     = (state_q == S_PRE) || (state_q == S_WAIT);
  assign done      = (state_q == S_DONE);
  assign triggered = trig_q;
  assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_cw_trig_capture.sv
// Bench for cw_trig_capture (DEPTH=16): directed and random captures against a stream-level model.
module tb_cw_trig_capture;
  localparam int NS = 96;

  logic        trig_clk = 1'b0;
  logic        trig_rst;
  logic [15:0] bus_din;
  logic        arm, abort;
  logic [3:0]  trig_mode;
  logic [15:0] trig_value, trig_mask;
  logic        trig_and;
  logic [3:0]  pre_len;
  logic [7:0]  trig_cnt;
  logic        wt_ce, wt_en, armed, triggered, done;
  logic [3:0]  wt_addr, trig_addr;
  logic [15:0] wt_data;

  int checks = 0;
  int failures = 0;
  logic [15:0] d [0:NS-1];

  cw_trig_capture #(.BUS_NUM(2), .BUS_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(8)) dut (
    .trig_clk(trig_clk), .trig_rst(trig_rst), .bus_din(bus_din), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_value(trig_value), .trig_mask(trig_mask), .trig_and(trig_and),
    .pre_len(pre_len), .trig_cnt(trig_cnt), .wt_ce(wt_ce), .wt_en(wt_en), .wt_addr(wt_addr),
    .wt_data(wt_data), .armed(armed), .triggered(triggered), .done(done), .trig_addr(trig_addr)
  );

  always #5 trig_clk = ~trig_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Combined trigger condition computed directly from the mode rules
  function automatic bit model_hit(input logic [15:0] s, input logic [15:0] p);
    int en, nh;
    logic [1:0] md;
    logic [7:0] sb, pb, vb, mb;
    en = 0; nh = 0;
    for (int b = 0; b < 2; b++) begin
      md = trig_mode[2*b +: 2];
      sb = s[8*b +: 8]; pb = p[8*b +: 8];
      vb = trig_value[8*b +: 8]; mb = trig_mask[8*b +: 8];
      if (md != 2'b00) begin
        en++;
        if (md == 2'b01 && (sb & mb) == (vb & mb)) nh++;
        if (md == 2'b10 && (sb & mb) != (vb & mb)) nh++;
        if (md == 2'b11 && ((sb ^ pb) & mb) != 0) nh++;
      end
    end
    if (en == 0) return 1'b1;
    return trig_and ? (nh == en) : (nh > 0);
  endfunction

  // Arms once, feeds d[] one sample per cycle and checks every cycle.
  // abort_at < 0: run to completion (or abort after 60 cycles if no trigger).
  task automatic run_cap(input string name, input int abort_at);
    int pe, tj, hits, need, total, lim, ab;
    pe = int'(pre_len);
    need = 1;
`ifdef CW_TRIG_CNT_EN
    need = (trig_cnt > 1) ? int'(trig_cnt) : 1;
`endif
    tj = -1; hits = 0;
    for (int j = pe; j < 64 && tj < 0; j++) begin
      if (model_hit(d[j], (j == 0) ? d[0] : d[j-1])) begin
        hits++;
        if (hits >= need) tj = j;
      end
    end
    total = (tj < 0) ? 100000 : tj + 16 - pe;
    ab = abort_at;
    if (tj < 0 && ab < 0) ab = 60;
    lim = (ab >= 0) ? ab : total + 1;

    @(negedge trig_clk); bus_din = d[0]; arm = 1'b0;
    @(negedge trig_clk); arm = 1'b1;
    @(negedge trig_clk); arm = 1'b0;
    for (int j = 0; j <= lim; j++) begin
      chk({name, ".wt_ce"}, wt_ce, j < total);
      chk({name, ".wt_en"}, wt_en, j < total);
      if (j < total) begin
        chk({name, ".wt_addr"}, wt_addr, j % 16);
        chk({name, ".wt_data"}, wt_data, d[j]);
      end
      chk({name, ".armed"}, armed, (tj < 0) || (j <= tj));
      chk({name, ".triggered"}, triggered, (tj >= 0) && (j > tj));
      chk({name, ".done"}, done, j >= total);
      if (tj >= 0 && j > tj) chk({name, ".trig_addr"}, trig_addr, tj % 16);
      bus_din = d[j+1];
      if (j == ab) begin
        abort = 1'b1;
        @(negedge trig_clk);
        abort = 1'b0;
        chk({name, ".abort_ce"}, wt_ce, 1'b0);
        chk({name, ".abort_armed"}, armed, 1'b0);
        chk({name, ".abort_done"}, done, 1'b0);
        chk({name, ".abort_trig"}, triggered, (tj >= 0) && (j > tj));
        if (tj >= 0 && j > tj) chk({name, ".abort_taddr"}, trig_addr, tj % 16);
        return;
      end
      @(negedge trig_clk);
    end
  endtask

  task automatic cfg(input logic [3:0] md, input logic [15:0] v, input logic [15:0] m,
                     input logic an, input logic [3:0] pl, input logic [7:0] tc);
    trig_mode = md; trig_value = v; trig_mask = m; trig_and = an; pre_len = pl; trig_cnt = tc;
  endtask

  initial begin
    logic [7:0] bv;
    int sel;
    trig_rst = 1'b1; arm = 1'b0; abort = 1'b0; bus_din = 16'h1234;
    cfg(4'b0000, 16'h0, 16'h0, 1'b0, 4'd0, 8'd0);
    #12;
    chk("rst.wt_ce", wt_ce, 1'b0);
    chk("rst.wt_addr", wt_addr, 4'h0);
    chk("rst.wt_data", wt_data, 16'h0);
    chk("rst.armed", armed, 1'b0);
    chk("rst.triggered", triggered, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.trig_addr", trig_addr, 4'h0);
    @(negedge trig_clk); trig_rst = 1'b0;

    // Ramp on bus0 matched against 0x5A, bus1 off
    cfg(4'b0001, 16'h005A, 16'h00FF, 1'b0, 4'd4, 8'd0);
    for (int j = 0; j < NS; j++) d[j] = {8'hC3, 8'(8'h50 + j)};
    run_cap("ramp", -1);

    // Change detect on bit0 after a long static stretch
    cfg(4'b0011, 16'h0, 16'h0001, 1'b0, 4'd2, 8'd0);
    for (int j = 0; j < NS; j++) d[j] = {8'($urandom), 7'($urandom), (j >= 22) ? 1'b1 : 1'b0};
    run_cap("change", -1);

    // Both buses must match, then either bus suffices
    for (int k = 0; k < 2; k++) begin
      cfg(4'b0101, 16'h2211, 16'hFFFF, (k == 0), 4'd1, 8'd0);
      for (int j = 0; j < NS; j++) d[j] = 16'h0000;
      d[5] = 16'h0011; d[6] = 16'h2200; d[7] = 16'h2211;
      run_cap((k == 0) ? "and" : "or", -1);
    end

    // Maximum pre-trigger depth with every bus off: no post samples
    cfg(4'b0000, 16'h0, 16'h0, 1'b0, 4'hF, 8'd0);
    for (int j = 0; j < NS; j++) d[j] = 16'(j * 7);
    run_cap("pre_max", -1);

    // Three match hits; count feature decides which one triggers
    cfg(4'b0001, 16'h00A5, 16'h00FF, 1'b0, 4'd2, 8'd3);
    for (int j = 0; j < NS; j++) d[j] = 16'h0000;
    d[5] = 16'h00A5; d[9] = 16'h00A5; d[14] = 16'h00A5;
    run_cap("count", -1);

    // Abort while in POST
    cfg(4'b0000, 16'h0, 16'h0, 1'b0, 4'd0, 8'd0);
    for (int j = 0; j < NS; j++) d[j] = 16'(j + 16'h100);
    run_cap("abort_post", 3);

    // arm and abort together from IDLE
    @(negedge trig_clk); arm = 1'b1; abort = 1'b1;
    @(negedge trig_clk); arm = 1'b0; abort = 1'b0;
    chk("armabort.wt_ce", wt_ce, 1'b0);
    chk("armabort.armed", armed, 1'b0);
    @(negedge trig_clk);
    chk("armabort.wt_ce2", wt_ce, 1'b0);

    // Random configurations and streams
    for (int n = 0; n < 40; n++) begin
      cfg(4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom),
          8'($urandom_range(0, 3)));
      for (int j = 0; j < NS; j++) begin
        for (int b = 0; b < 2; b++) begin
          sel = $urandom_range(0, 3);
          bv = (sel == 0) ? trig_value[8*b +: 8]
             : (sel == 1 && j > 0) ? d[j-1][8*b +: 8]
             : (sel == 2) ? (trig_value[8*b +: 8] ^ (8'h1 << $urandom_range(0, 7)))
             : 8'($urandom);
          d[j][8*b +: 8] = bv;
        end
      end
      run_cap("rand", ($urandom_range(0, 7) == 0) ? $urandom_range(0, 30) : -1);
    end

    // Asynchronous reset in the middle of a capture
    cfg(4'b0000, 16'h0, 16'h0, 1'b0, 4'd5, 8'd0);
    bus_din = 16'hBEEF;
    @(negedge trig_clk); arm = 1'b1;
    @(negedge trig_clk); arm = 1'b0;
    @(negedge trig_clk);
    @(posedge trig_clk); #2 trig_rst = 1'b1; #1;
    chk("arst.wt_ce", wt_ce, 1'b0);
    chk("arst.armed", armed, 1'b0);
    chk("arst.wt_addr", wt_addr, 4'h0);
    chk("arst.wt_data", wt_data, 16'h0);
    @(negedge trig_clk); trig_rst = 1'b0;
    @(negedge trig_clk);
    chk("arst.idle", wt_ce, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
